fetch_ctrl: RTL and testbench
=============================

FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 SHALL have parameter QUEUE_DEPTH, default 16, the instruction-queue entry count; legal values are powers of two, at least 2.
REQ-002 SHALL have parameter RESET_PC, default 32'h1eceb000, the first fetch address after reset.
REQ-003 SHALL have port clk, input, 1 bit: the only clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-005 SHALL have port redirect_valid, input, 1 bit: a flush/redirect request from the backend.
REQ-006 SHALL have port redirect_pc, input, 32 bits: the new fetch address; bits [1:0] are ignored and forced to 0.
REQ-007 SHALL have port q_free, input, $clog2(QUEUE_DEPTH)+1 bits: free instruction-queue entries, as of the previous edge.
REQ-008 SHALL have port imem_addr, output, 32 bits: the request address.
REQ-009 SHALL have port imem_rmask, output, 4 bits: the read mask; 4'hF while a request is outstanding, else 4'h0.
REQ-010 SHALL have port imem_resp, input, 1 bit: the response strobe.
REQ-011 SHALL have port imem_rdata, input, 32 bits: the instruction word, valid only when imem_resp is high.
REQ-012 SHALL have port enq_valid, output, 1 bit: push strobe to the instruction queue.
REQ-013 SHALL have port enq_pc, output, 32 bits: PC of the pushed instruction.
REQ-014 SHALL have port enq_inst, output, 32 bits: the pushed instruction word.
REQ-015 SHALL have port fetch_count, output, 32 bits: count of instructions enqueued since reset.

Function
REQ-016 SHALL implement FSM states IDLE (no request outstanding), WAIT (live request outstanding) and FLUSH (stale request outstanding).
REQ-017 SHALL keep at most one imem request outstanding.
REQ-018 SHALL drive imem_addr and imem_rmask from registers, holding both stable from issue until the cycle imem_resp is high.
REQ-019 SHALL compute credit = (q_free > enq_valid), using zero-extended comparison.
REQ-020 In IDLE with credit and no redirect, SHALL issue a request at pc next cycle and enter WAIT.
REQ-021 In IDLE with no credit, SHALL remain in IDLE with imem_rmask = 0.
REQ-022 In IDLE with redirect_valid, SHALL set pc to redirect_pc and remain in IDLE; issue follows on a later cycle.
REQ-023 In WAIT with imem_resp and no redirect, SHALL assert enq_valid in the same cycle (combinational, zero latency), with enq_pc = imem_addr and enq_inst = imem_rdata.
REQ-024 In the REQ-023 case, SHALL set pc to pc+4 (wrapping modulo 2^32), then enter WAIT with the new address on the next cycle if credit, else enter IDLE.
REQ-025 In WAIT with imem_resp and redirect_valid in the same cycle, SHALL discard the response (enq_valid = 0), set pc to redirect_pc and enter IDLE.
REQ-026 In WAIT with redirect_valid and no imem_resp, SHALL set pc to redirect_pc and enter FLUSH.
REQ-027 In FLUSH with imem_resp, SHALL discard the response and enter IDLE.
REQ-028 In FLUSH with a further redirect_valid, SHALL overwrite pc with the latest redirect_pc.
REQ-029 SHALL never assert enq_valid outside WAIT.
REQ-030 SHALL never assert enq_valid when credit is 0, so that no instruction is ever dropped.
REQ-031 SHALL increment fetch_count by 1 on each enq_valid, wrapping at 2^32.
REQ-032 SHALL ignore imem_resp in IDLE.

Reset
REQ-033 On rst, SHALL immediately set state = IDLE, pc = RESET_PC, imem_addr = RESET_PC, imem_rmask = 0, enq_valid = 0, enq_pc = 0, enq_inst = 0 and fetch_count = 0.
REQ-034 Reset asserted mid-WAIT or mid-FLUSH SHALL abandon the outstanding request; a late response arriving after reset SHALL be ignored per REQ-032.
REQ-035 The first request SHALL appear no earlier than the first rising edge after rst deasserts.

Structure
REQ-036 The state enum fetch_ctrl_state_t (IDLE, WAIT, FLUSH) and struct fetch_pkt_t {pc, inst} SHALL live in rv32i_types.
REQ-037 SHALL be a single flat module with no sub-module; it feeds the existing instruction queue, which stays external.

Verification
REQ-038 Reset scenario: release rst, q_free = 16, imem_resp tied high -> request at 0x1eceb000, then enq_pc sequence 0x1eceb000, 0x1eceb004, 0x1eceb008, one per cycle.
REQ-039 Credit scenario: q_free = 0 -> imem_rmask stays 0; raise q_free = 1 -> exactly one enq, then return to IDLE.
REQ-040 Redirect-in-WAIT scenario: redirect to 0x00001003 with no imem_resp, then imem_resp 3 cycles later -> no enq; next request at 0x00001000.
REQ-041 Simultaneous scenario: imem_resp and redirect_valid in the same cycle -> enq_valid = 0, pc = redirect_pc, fetch_count unchanged.
REQ-042 Wrap scenario: redirect to 0xFFFFFFFC and accept a response -> next imem_addr = 0x00000000.
REQ-043 Reset-mid-WAIT scenario: assert rst during WAIT, then a stray imem_resp -> enq_valid = 0, fetch_count = 0.

Source files
------------

// File: rtl/rv32i_types.sv
// Shared RV32I frontend types.
// Fetch controller state and packet definitions.
package rv32i_types;

    localparam int XLEN = 32;

    localparam logic [3:0] RMASK_WORD = 4'hF;
    localparam logic [3:0] RMASK_NONE = 4'h0;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        FLUSH
    } fetch_ctrl_state_t;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] inst;
    } fetch_pkt_t;

    // Instruction addresses are always word aligned.
    function automatic logic [XLEN-1:0] align_pc(
        input logic [XLEN-1:0] a
    );
        return {a[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_ctrl.sv
// Instruction fetch controller.
// One outstanding imem request, credit-gated enqueue.
module fetch_ctrl
    import rv32i_types::*;
#(
    parameter int          QUEUE_DEPTH = 16,
    parameter logic [31:0] RESET_PC    = 32'h1eceb000
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             redirect_valid,
    input  logic [31:0]                      redirect_pc,
    input  logic [$clog2(QUEUE_DEPTH):0]     q_free,
    output logic [31:0]                      imem_addr,
    output logic [3:0]                       imem_rmask,
    input  logic                             imem_resp,
    input  logic [31:0]                      imem_rdata,
    output logic                             enq_valid,
    output logic [31:0]                      enq_pc,
    output logic [31:0]                      enq_inst,
    output logic [31:0]                      fetch_count
);

    localparam int QW = $clog2(QUEUE_DEPTH) + 1;

    fetch_ctrl_state_t state_q, state_d;

    logic [31:0] pc_q, pc_d;
    logic [31:0] addr_q, addr_d;
    logic [3:0]  rmask_q, rmask_d;
    logic [31:0] count_q;

    logic        room;
    logic        push;
    logic        credit;
    logic [31:0] pc_inc;
    logic [31:0] redir_pc;
    fetch_pkt_t  pkt;

    // Push qualification and credit for the next issue.
    always_comb begin
        room     = (q_free != '0);
        push     = (state_q == WAIT) && imem_resp
                   && !redirect_valid && room;
        credit   = (q_free > {{(QW-1){1'b0}}, push});
        pc_inc   = pc_q + 32'd4;
        redir_pc = align_pc(redirect_pc);
    end

    // Enqueue bundle; zero whenever nothing is pushed.
    always_comb begin
        pkt = '0;
        if (push) begin
            pkt.pc   = addr_q;
            pkt.inst = imem_rdata;
        end
    end

    // Next-state, next-pc and request register decode.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        addr_d  = addr_q;
        rmask_d = rmask_q;
        unique case (state_q)
            IDLE: begin
                if (redirect_valid) begin
                    pc_d = redir_pc;
                end else if (credit) begin
                    addr_d  = pc_q;
                    rmask_d = RMASK_WORD;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (redirect_valid) begin
                    pc_d = redir_pc;
                    if (imem_resp) begin
                        rmask_d = RMASK_NONE;
                        state_d = IDLE;
                    end else begin
                        state_d = FLUSH;
                    end
                end else if (imem_resp) begin
                    if (push) begin
                        pc_d = pc_inc;
                        if (credit) begin
                            addr_d  = pc_inc;
                            rmask_d = RMASK_WORD;
                            state_d = WAIT;
                        end else begin
                            rmask_d = RMASK_NONE;
                            state_d = IDLE;
                        end
                    end else begin
                        // No queue room: drop and refetch same pc.
                        rmask_d = RMASK_NONE;
                        state_d = IDLE;
                    end
                end
            end
            FLUSH: begin
                if (redirect_valid) begin
                    pc_d = redir_pc;
                end
                if (imem_resp) begin
                    rmask_d = RMASK_NONE;
                    state_d = IDLE;
                end
            end
            default: begin
                rmask_d = RMASK_NONE;
                state_d = IDLE;
            end
        endcase
    end

    // State, pc and request registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            pc_q    <= RESET_PC;
            addr_q  <= RESET_PC;
            rmask_q <= RMASK_NONE;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            addr_q  <= addr_d;
            rmask_q <= rmask_d;
        end
    end

    // Count of enqueued instructions, wraps naturally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else if (push) begin
            count_q <= count_q + 32'd1;
        end
    end

    assign imem_addr   = addr_q;
    assign imem_rmask  = rmask_q;
    assign enq_valid   = push;
    assign enq_pc      = pkt.pc;
    assign enq_inst    = pkt.inst;
    assign fetch_count = count_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Testbench for fetch_ctrl.
// Scenario tasks plus an enqueue scoreboard.
module tb_fetch_ctrl;

    localparam logic [31:0] RPC = 32'h1eceb000;

    logic        clk;
    logic        rst;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [4:0]  q_free;
    logic [31:0] imem_addr;
    logic [3:0]  imem_rmask;
    logic        imem_resp;
    logic [31:0] imem_rdata;
    logic        enq_valid;
    logic [31:0] enq_pc;
    logic [31:0] enq_inst;
    logic [31:0] fetch_count;

    int checks   = 0;
    int failures = 0;

    logic [31:0] exp_q[$];

    fetch_ctrl dut (
        .clk            (clk),
        .rst            (rst),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .q_free         (q_free),
        .imem_addr      (imem_addr),
        .imem_rmask     (imem_rmask),
        .imem_resp      (imem_resp),
        .imem_rdata     (imem_rdata),
        .enq_valid      (enq_valid),
        .enq_pc         (enq_pc),
        .enq_inst       (enq_inst),
        .fetch_count    (fetch_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] inst_of(input logic [31:0] a);
        return (a ^ 32'hA5A50F0F) + 32'h00000013;
    endfunction

    assign imem_rdata = inst_of(imem_addr);

    // Scoreboard: every push must match the oldest expected pc.
    always @(negedge clk) begin
        if (enq_valid) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_enq pc=%h", enq_pc);
            end else begin
                logic [31:0] e;
                e = exp_q.pop_front();
                if (enq_pc !== e || enq_inst !== inst_of(e)) begin
                    failures++;
                    $display("FAIL enq pc=%h inst=%h want pc=%h inst=%h",
                             enq_pc, enq_inst, e, inst_of(e));
                end
            end
            checks++;
            if (q_free === 5'd0) begin
                failures++;
                $display("FAIL enq_no_credit q_free=%0d want >0", q_free);
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic reset_dut();
        rst            = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        imem_resp      = 1'b0;
        q_free         = 5'd16;
        exp_q.delete();
        step(2);
    endtask

    task automatic test_reset();
        reset_dut();
        checks++;
        if (imem_addr !== RPC || imem_rmask !== 4'h0 || enq_valid !== 1'b0
            || enq_pc !== 32'h0 || enq_inst !== 32'h0
            || fetch_count !== 32'h0) begin
            failures++;
            $display("FAIL reset_state addr=%h rmask=%h ev=%b pc=%h inst=%h cnt=%0d",
                     imem_addr, imem_rmask, enq_valid, enq_pc, enq_inst,
                     fetch_count);
        end
        imem_resp = 1'b1;
        exp_q.push_back(RPC);
        exp_q.push_back(RPC + 32'd4);
        exp_q.push_back(RPC + 32'd8);
        rst = 1'b0;
        step(1);
        checks++;
        if (imem_addr !== RPC || imem_rmask !== 4'hF) begin
            failures++;
            $display("FAIL first_req addr=%h rmask=%h want %h F",
                     imem_addr, imem_rmask, RPC);
        end
        step(3);
        imem_resp = 1'b0;
        checks++;
        if (fetch_count !== 32'd3 || exp_q.size() != 0
            || imem_addr !== RPC + 32'd12) begin
            failures++;
            $display("FAIL stream cnt=%0d left=%0d addr=%h want 3 0 %h",
                     fetch_count, exp_q.size(), imem_addr, RPC + 32'd12);
        end
    endtask

    task automatic test_credit();
        reset_dut();
        q_free = 5'd0;
        rst    = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step(1);
            checks++;
            if (imem_rmask !== 4'h0) begin
                failures++;
                $display("FAIL no_credit_rmask cyc=%0d rmask=%h want 0",
                         i, imem_rmask);
            end
        end
        q_free = 5'd1;
        step(1);
        checks++;
        if (imem_rmask !== 4'hF || imem_addr !== RPC) begin
            failures++;
            $display("FAIL credit_issue addr=%h rmask=%h want %h F",
                     imem_addr, imem_rmask, RPC);
        end
        exp_q.push_back(RPC);
        imem_resp = 1'b1;
        step(1);
        q_free    = 5'd0;
        imem_resp = 1'b0;
        checks++;
        if (imem_rmask !== 4'h0) begin
            failures++;
            $display("FAIL credit_idle rmask=%h want 0", imem_rmask);
        end
        step(3);
        checks++;
        if (imem_rmask !== 4'h0 || fetch_count !== 32'd1
            || exp_q.size() != 0) begin
            failures++;
            $display("FAIL credit_one rmask=%h cnt=%0d left=%0d want 0 1 0",
                     imem_rmask, fetch_count, exp_q.size());
        end
    endtask

    task automatic test_redirect_wait();
        reset_dut();
        rst = 1'b0;
        step(1);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h00001003;
        step(1);
        redirect_valid = 1'b0;
        checks++;
        if (imem_rmask !== 4'hF || imem_addr !== RPC) begin
            failures++;
            $display("FAIL flush_hold addr=%h rmask=%h want %h F",
                     imem_addr, imem_rmask, RPC);
        end
        step(2);
        imem_resp = 1'b1;
        step(1);
        imem_resp = 1'b0;
        checks++;
        if (imem_rmask !== 4'h0 || fetch_count !== 32'd0) begin
            failures++;
            $display("FAIL flush_drop rmask=%h cnt=%0d want 0 0",
                     imem_rmask, fetch_count);
        end
        step(1);
        checks++;
        if (imem_addr !== 32'h00001000 || imem_rmask !== 4'hF) begin
            failures++;
            $display("FAIL redirect_req addr=%h rmask=%h want 00001000 F",
                     imem_addr, imem_rmask);
        end
        exp_q.push_back(32'h00001000);
        imem_resp = 1'b1;
        step(1);
        imem_resp = 1'b0;
        checks++;
        if (imem_addr !== 32'h00001004 || fetch_count !== 32'd1
            || exp_q.size() != 0) begin
            failures++;
            $display("FAIL redirect_next addr=%h cnt=%0d left=%0d",
                     imem_addr, fetch_count, exp_q.size());
        end
    endtask

    task automatic test_simultaneous();
        reset_dut();
        rst = 1'b0;
        step(1);
        imem_resp      = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h00002000;
        #1;
        checks++;
        if (enq_valid !== 1'b0) begin
            failures++;
            $display("FAIL simul_enq enq_valid=%b want 0", enq_valid);
        end
        step(1);
        imem_resp      = 1'b0;
        redirect_valid = 1'b0;
        checks++;
        if (imem_rmask !== 4'h0 || fetch_count !== 32'd0) begin
            failures++;
            $display("FAIL simul_idle rmask=%h cnt=%0d want 0 0",
                     imem_rmask, fetch_count);
        end
        step(1);
        checks++;
        if (imem_addr !== 32'h00002000 || imem_rmask !== 4'hF) begin
            failures++;
            $display("FAIL simul_req addr=%h rmask=%h want 00002000 F",
                     imem_addr, imem_rmask);
        end
    endtask

    task automatic test_wrap();
        reset_dut();
        rst            = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFFFFFC;
        step(1);
        redirect_valid = 1'b0;
        step(1);
        checks++;
        if (imem_addr !== 32'hFFFFFFFC || imem_rmask !== 4'hF) begin
            failures++;
            $display("FAIL wrap_req addr=%h rmask=%h want FFFFFFFC F",
                     imem_addr, imem_rmask);
        end
        exp_q.push_back(32'hFFFFFFFC);
        imem_resp = 1'b1;
        step(1);
        imem_resp = 1'b0;
        checks++;
        if (imem_addr !== 32'h00000000 || fetch_count !== 32'd1
            || exp_q.size() != 0) begin
            failures++;
            $display("FAIL wrap_next addr=%h cnt=%0d left=%0d want 0 1 0",
                     imem_addr, fetch_count, exp_q.size());
        end
    endtask

    task automatic test_reset_mid_wait();
        reset_dut();
        rst = 1'b0;
        step(1);
        exp_q.push_back(RPC);
        imem_resp = 1'b1;
        step(1);
        imem_resp = 1'b0;
        checks++;
        if (fetch_count !== 32'd1 || imem_rmask !== 4'hF) begin
            failures++;
            $display("FAIL pre_rst cnt=%0d rmask=%h want 1 F",
                     fetch_count, imem_rmask);
        end
        #1;
        rst = 1'b1;
        #1;
        checks++;
        if (fetch_count !== 32'd0 || imem_rmask !== 4'h0
            || imem_addr !== RPC || enq_valid !== 1'b0) begin
            failures++;
            $display("FAIL async_rst cnt=%0d rmask=%h addr=%h ev=%b",
                     fetch_count, imem_rmask, imem_addr, enq_valid);
        end
        step(1);
        q_free    = 5'd0;
        imem_resp = 1'b1;
        rst       = 1'b0;
        #1;
        checks++;
        if (enq_valid !== 1'b0) begin
            failures++;
            $display("FAIL stray_enq enq_valid=%b want 0", enq_valid);
        end
        step(2);
        imem_resp = 1'b0;
        checks++;
        if (fetch_count !== 32'd0 || imem_rmask !== 4'h0
            || exp_q.size() != 0) begin
            failures++;
            $display("FAIL stray_resp cnt=%0d rmask=%h left=%0d want 0 0 0",
                     fetch_count, imem_rmask, exp_q.size());
        end
    endtask

    initial begin
        rst            = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        q_free         = 5'd16;
        imem_resp      = 1'b0;
        test_reset();
        test_credit();
        test_redirect_wait();
        test_simultaneous();
        test_wrap();
        test_reset_mid_wait();
        step(2);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
